// File: rtl/data_sync.sv
// Multi-flop bus synchronizer: an enable qualifier crosses an NUM_STAGES flop chain, and its
// synchronized rising edge strobes ENABLE_PULSE and captures UNSYNC_BUS into SYNC_BUS.
// Optional sticky BUS_ERR stability flag is built when DATA_SYNC_STABILITY_CHECK_EN is defined.
module data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE
`ifdef DATA_SYNC_STABILITY_CHECK_EN
    ,
    output logic                 BUS_ERR
`endif
);

    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("data_sync: NUM_STAGES must be in 2..4");
        end
        if (BUS_WIDTH < 1) begin : g_bad_width
            $error("data_sync: BUS_WIDTH must be at least 1");
        end
    endgenerate

    logic [NUM_STAGES-1:0] r_sync_q;
    logic                  r_en_d;
    logic                  r_enable_pulse;
    logic [BUS_WIDTH-1:0]  r_sync_bus;
    logic                  w_en_s;
    logic                  w_rise;

    assign w_en_s = r_sync_q[NUM_STAGES-1];
    assign w_rise = w_en_s & ~r_en_d;

    // Only the enable crosses through the chain; the bus is sampled once the enable has settled.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync_q <= '0;
            r_en_d   <= 1'b0;
        end else begin
            r_sync_q <= {r_sync_q[NUM_STAGES-2:0], BUS_ENABLE};
            r_en_d   <= w_en_s;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_enable_pulse <= 1'b0;
            r_sync_bus     <= '0;
        end else begin
            r_enable_pulse <= w_rise;
            if (w_rise) begin
                r_sync_bus <= UNSYNC_BUS;
            end
        end
    end

    assign SYNC_BUS     = r_sync_bus;
    assign ENABLE_PULSE = r_enable_pulse;

`ifdef DATA_SYNC_STABILITY_CHECK_EN
    logic r_bus_err;
    logic w_unstable;

    // Enable still high after capture but the source bus no longer matches what was taken.
    assign w_unstable = w_en_s & r_en_d & (UNSYNC_BUS != r_sync_bus);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_bus_err <= 1'b0;
        end else if (w_unstable) begin
            r_bus_err <= 1'b1;
        end
    end

    assign BUS_ERR = r_bus_err;
`endif

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: two instances (2 and 4 stages) share stimulus and are checked against an
// edge-history reference model. Exercises BUS_ERR when DATA_SYNC_STABILITY_CHECK_EN is defined.
module tb_data_sync;

    logic       clk;
    logic       rst_n;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic [7:0] b2, b4;
    logic       p2, p4;
`ifdef DATA_SYNC_STABILITY_CHECK_EN
    logic       e2, e4;
`endif

    int n_checks;
    int n_errors;

    // Reference model state: enable/bus values seen at each edge since reset release.
    logic       en_hist[$];
    logic [7:0] bus_hist[$];
    logic       m_p2, m_p4, m_e2, m_e4;
    logic [7:0] m_b2, m_b4;
    logic [7:0] exp_q[$];

    data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
        .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(unsync_bus), .BUS_ENABLE(bus_enable),
        .SYNC_BUS(b2), .ENABLE_PULSE(p2)
`ifdef DATA_SYNC_STABILITY_CHECK_EN
        , .BUS_ERR(e2)
`endif
    );

    data_sync #(.NUM_STAGES(4), .BUS_WIDTH(8)) dut4 (
        .CLK(clk), .RST_n(rst_n), .UNSYNC_BUS(unsync_bus), .BUS_ENABLE(bus_enable),
        .SYNC_BUS(b4), .ENABLE_PULSE(p4)
`ifdef DATA_SYNC_STABILITY_CHECK_EN
        , .BUS_ERR(e4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic en_at(int k);
        if (k < 0) return 1'b0;
        return en_hist[k];
    endfunction

    // A word is delivered n edges after the enable was first seen high (having been low before).
    task automatic model_edge(input int n, input int j, inout logic p, inout logic [7:0] b,
                              inout logic e);
        logic s_now, s_prev;
        s_now  = en_at(j - n);
        s_prev = en_at(j - n - 1);
        if (s_now && s_prev && (bus_hist[j] != b)) e = 1'b1;
        p = s_now & ~s_prev;
        if (p) b = bus_hist[j];
    endtask

    task automatic tick();
        int j;
        @(posedge clk);
        if (!rst_n) begin
            en_hist.delete();
            bus_hist.delete();
            {m_p2, m_p4, m_e2, m_e4} = '0;
            m_b2 = '0;
            m_b4 = '0;
        end else begin
            en_hist.push_back(bus_enable);
            bus_hist.push_back(unsync_bus);
            j = en_hist.size() - 1;
            model_edge(2, j, m_p2, m_b2, m_e2);
            model_edge(4, j, m_p4, m_b4, m_e4);
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int c2, c4;
        bus_enable = 1'b1;
        unsync_bus = 8'hA5;
        rst_n      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({p2, b2, p4, b4} !== 18'd0) begin
                n_errors++;
                $display("FAIL reset_hold: got p2=%b b2=%h p4=%b b4=%h required all 0", p2, b2, p4, b4);
            end
        end
        rst_n = 1'b1;
        c2 = 0;
        c4 = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            c2 += int'(p2);
            c4 += int'(p4);
            n_checks++;
            if ({p2, p4} !== {k == 2, k == 4}) begin
                n_errors++;
                $display("FAIL reset_release_pulse k=%0d: got p2=%b p4=%b required p2=%b p4=%b",
                         k, p2, p4, k == 2, k == 4);
            end
            n_checks++;
            if ({p2, b2, p4, b4} !== {m_p2, m_b2, m_p4, m_b4}) begin
                n_errors++;
                $display("FAIL reset_model k=%0d: got %b/%h %b/%h required %b/%h %b/%h",
                         k, p2, b2, p4, b4, m_p2, m_b2, m_p4, m_b4);
            end
        end
        n_checks++;
        if (c2 != 1 || c4 != 1 || b2 !== 8'hA5 || b4 !== 8'hA5) begin
            n_errors++;
            $display("FAIL reset_release_once: got pulses %0d/%0d bus %h/%h required 1/1 a5/a5",
                     c2, c4, b2, b4);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        bus_enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        unsync_bus = 8'h3C;
        bus_enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            n_checks++;
            if ({p2, p4} !== {k == 2, k == 4}) begin
                n_errors++;
                $display("FAIL latency_pulse k=%0d: got p2=%b p4=%b required p2=%b p4=%b",
                         k, p2, p4, k == 2, k == 4);
            end
            if (k >= 2) begin
                n_checks++;
                if (b2 !== 8'h3C || (k >= 4 && b4 !== 8'h3C)) begin
                    n_errors++;
                    $display("FAIL latency_bus k=%0d: got b2=%h b4=%h required 3c", k, b2, b4);
                end
            end
        end
        bus_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[3];
        int         c2;
        logic [7:0] exp_w;
        words = '{8'h11, 8'h22, 8'h33};
        apply_reset();
        bus_enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        exp_q.delete();
        c2 = 0;
        for (int w = 0; w < 3; w++) exp_q.push_back(words[w]);
        for (int w = 0; w < 6 * 3 + 6; w++) begin
            if (w % 8 == 0 && w / 8 < 3) begin
                unsync_bus = words[w / 8];
                bus_enable = 1'b1;
            end else if (w % 8 == 4) begin
                bus_enable = 1'b0;
            end
            tick();
            n_checks++;
            if ({p2, b2, p4, b4} !== {m_p2, m_b2, m_p4, m_b4}) begin
                n_errors++;
                $display("FAIL b2b_model cyc=%0d: got %b/%h %b/%h required %b/%h %b/%h",
                         w, p2, b2, p4, b4, m_p2, m_b2, m_p4, m_b4);
            end
            if (p2) begin
                c2++;
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_checks++;
                if (b2 !== exp_w) begin
                    n_errors++;
                    $display("FAIL b2b_word: got %h required %h", b2, exp_w);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            c2 += int'(p2);
        end
        n_checks++;
        if (c2 != 3 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d pulses, %0d words left required 3 pulses, 0 left",
                     c2, exp_q.size());
        end
`ifdef DATA_SYNC_STABILITY_CHECK_EN
        n_checks++;
        if ({e2, e4} !== 2'b00) begin
            n_errors++;
            $display("FAIL clean_bus_err: got %b%b required 00", e2, e4);
        end
`endif
    endtask

    task automatic test_long_enable();
        int c2, c4;
        apply_reset();
        bus_enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        unsync_bus = 8'hF0;
        bus_enable = 1'b1;
        c2 = 0;
        c4 = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 50) bus_enable = 1'b0;
            tick();
            c2 += int'(p2);
            c4 += int'(p4);
        end
        n_checks++;
        if (c2 != 1 || c4 != 1 || b2 !== 8'hF0 || b4 !== 8'hF0) begin
            n_errors++;
            $display("FAIL long_enable: got pulses %0d/%0d bus %h/%h required 1/1 f0/f0",
                     c2, c4, b2, b4);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        apply_reset();
        bus_enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        unsync_bus = 8'h77;
        bus_enable = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({p2, b2, p4, b4} !== 18'd0) begin
            n_errors++;
            $display("FAIL reset_mid_assert: got %b/%h %b/%h required all 0", p2, b2, p4, b4);
        end
        bus_enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        c = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            c += int'(p2) + int'(p4);
        end
        n_checks++;
        if (c != 0 || b2 !== 8'h00 || b4 !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid: got %0d pulses bus %h/%h required 0 pulses 00/00", c, b2, b4);
        end
    endtask

    task automatic test_random();
        int hi, lo;
        apply_reset();
        bus_enable = 1'b0;
        for (int w = 0; w < 30; w++) begin
            unsync_bus = 8'($urandom);
            bus_enable = 1'b1;
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 6);
            for (int k = 0; k < hi + lo; k++) begin
                if (k == hi) bus_enable = 1'b0;
                tick();
                n_checks++;
                if ({p2, b2, p4, b4} !== {m_p2, m_b2, m_p4, m_b4}) begin
                    n_errors++;
                    $display("FAIL random w=%0d k=%0d: got %b/%h %b/%h required %b/%h %b/%h",
                             w, k, p2, b2, p4, b4, m_p2, m_b2, m_p4, m_b4);
                end
            end
        end
    endtask

`ifdef DATA_SYNC_STABILITY_CHECK_EN
    task automatic test_stability();
        bus_enable = 1'b1;
        unsync_bus = 8'h55;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 4) unsync_bus = 8'h56;
            n_checks++;
            if ({e2, e4} !== {m_e2, m_e4} || {p2, b2, p4, b4} !== {m_p2, m_b2, m_p4, m_b4}) begin
                n_errors++;
                $display("FAIL stability_model k=%0d: got err %b%b required %b%b", k, e2, e4, m_e2, m_e4);
            end
            n_checks++;
            if (e2 !== (k >= 5) || (k >= 2 && b2 !== 8'h55)) begin
                n_errors++;
                $display("FAIL stability k=%0d: got err=%b bus=%h required err=%b bus=55",
                         k, e2, b2, k >= 5);
            end
        end
        bus_enable = 1'b0;
        apply_reset();
        n_checks++;
        if ({e2, e4} !== 2'b00) begin
            n_errors++;
            $display("FAIL stability_reset: got err %b%b required 00", e2, e4);
        end
    endtask
`endif

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus_enable = 1'b0;
        unsync_bus = 8'h00;
        {m_p2, m_p4, m_e2, m_e4} = '0;
        m_b2 = '0;
        m_b4 = '0;
        #2;
        test_reset();
        test_latency();
        test_back_to_back();
        test_long_enable();
        test_reset_mid();
`ifdef DATA_SYNC_STABILITY_CHECK_EN
        test_stability();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
